srom_single_port_arbiter: RTL and testbench

Shares one SROM_Single_Port_8_Bit instance between NUM_REQ independent read requesters. Each requester uses a valid/ready request channel and a valid/ready response channel, and requesters are granted in round-robin order. The block sequences the SROM's Enable/Read_Enable/Address pins so that the gated, registered read data is sampled while the output is driven, never while it is Z. It sits between client logic (CPU fetch, table-lookup units) and the ROM macro.

---
 rtl/srom_arbiter_pkg.sv | 16 +
 rtl/rr_priority_picker.sv | 34 +++
 rtl/srom_single_port_arbiter.sv | 100 ++++++++++
 tb/tb_srom_single_port_arbiter.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/srom_arbiter_pkg.sv
// Shared types and defaults for the single-port SROM read arbiter.
package srom_arbiter_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} arb_state_t;

    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_ADDR_WIDTH = 4;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_CNT_WIDTH  = 16;

    // Index width that never collapses to zero bits for tiny requester counts.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_priority_picker
    import srom_arbiter_pkg::*;
#(
    parameter int N     = DEF_NUM_REQ,
    parameter int IDX_W = clog2_min1(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             any_req
);

    always_comb begin
        int   j;
        logic found;
        grant     = '0;
        grant_idx = '0;
        any_req   = |req;
        found     = 1'b0;
        j         = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            if (!found && req[j]) begin
                found     = 1'b1;
                grant[j]  = 1'b1;
                grant_idx = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/srom_single_port_arbiter.sv
// Round-robin sharing of one registered-output SROM among NUM_REQ read clients.
module srom_single_port_arbiter
    import srom_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH,
    parameter int GW         = clog2_min1(NUM_REQ)
) (
    input  logic                          Clk_In,
    input  logic                          Reset_In,
    input  logic [NUM_REQ-1:0]            Req_Valid_In,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] Req_Address_In,
    output logic [NUM_REQ-1:0]            Req_Ready_Out,
    output logic [NUM_REQ-1:0]            Rsp_Valid_Out,
    input  logic [NUM_REQ-1:0]            Rsp_Ready_In,
    output logic [DATA_WIDTH-1:0]         Rsp_Data_Out,
    output logic [GW-1:0]                 Grant_Id_Out,
    output logic                          Busy_Out,
    output logic [CNT_WIDTH-1:0]          Read_Count_Out,
    output logic                          SROM_Enable_Out,
    output logic                          SROM_Read_Enable_Out,
    output logic [ADDR_WIDTH-1:0]         SROM_Address_Out,
    input  logic [DATA_WIDTH-1:0]         SROM_Read_Data_In
);

    arb_state_t          state;
    logic [GW-1:0]       ptr;
    logic [NUM_REQ-1:0]  pick_grant;
    logic [GW-1:0]       pick_idx;
    logic                pick_any;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [GW-1:0]       next_ptr;
    logic [NUM_REQ-1:0]  owner_onehot;

    rr_priority_picker #(.N(NUM_REQ), .IDX_W(GW)) u_picker (
        .req       (Req_Valid_In),
        .ptr       (ptr),
        .grant     (pick_grant),
        .grant_idx (pick_idx),
        .any_req   (pick_any)
    );

    assign Req_Ready_Out = (state == IDLE) ? pick_grant : '0;
    assign sel_addr      = Req_Address_In[int'(pick_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    assign next_ptr      = (pick_idx == GW'(NUM_REQ-1)) ? '0 : pick_idx + GW'(1);
    assign owner_onehot  = NUM_REQ'(1) << Grant_Id_Out;

    // SROM pins are registered so they are high for exactly ISSUE and CAPTURE,
    // and the async reset drops them without waiting for an edge.
    always_ff @(posedge Clk_In or posedge Reset_In) begin
        if (Reset_In) begin
            state                <= IDLE;
            ptr                  <= '0;
            Grant_Id_Out         <= '0;
            Busy_Out             <= 1'b0;
            Rsp_Valid_Out        <= '0;
            Rsp_Data_Out         <= '0;
            Read_Count_Out       <= '0;
            SROM_Enable_Out      <= 1'b0;
            SROM_Read_Enable_Out <= 1'b0;
            SROM_Address_Out     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pick_any) begin
                        Grant_Id_Out         <= pick_idx;
                        ptr                  <= next_ptr;
                        Busy_Out             <= 1'b1;
                        SROM_Enable_Out      <= 1'b1;
                        SROM_Read_Enable_Out <= 1'b1;
                        SROM_Address_Out     <= sel_addr;
                        state                <= ISSUE;
                    end
                end
                ISSUE: state <= CAPTURE;
                CAPTURE: begin
                    // ROM output is driven now; sample before releasing the pins.
                    Rsp_Data_Out         <= SROM_Read_Data_In;
                    if (Read_Count_Out != '1) Read_Count_Out <= Read_Count_Out + 1'b1;
                    Rsp_Valid_Out        <= owner_onehot;
                    SROM_Enable_Out      <= 1'b0;
                    SROM_Read_Enable_Out <= 1'b0;
                    SROM_Address_Out     <= '0;
                    state                <= RESP;
                end
                RESP: begin
                    if (Rsp_Ready_In[Grant_Id_Out]) begin
                        Rsp_Valid_Out <= '0;
                        Busy_Out      <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_srom_single_port_arbiter.sv
// Randomized bench for srom_single_port_arbiter with a behavioural SROM and transaction model.
module tb_srom_single_port_arbiter;

    localparam int N  = 4;
    localparam int AW = 4;
    localparam int DW = 8;
    localparam int CW = 4;
    localparam int GW = 2;

    logic            Clk_In = 1'b0;
    logic            Reset_In;
    logic [N-1:0]    Req_Valid_In;
    logic [N*AW-1:0] Req_Address_In;
    logic [N-1:0]    Req_Ready_Out;
    logic [N-1:0]    Rsp_Valid_Out;
    logic [N-1:0]    Rsp_Ready_In;
    logic [DW-1:0]   Rsp_Data_Out;
    logic [GW-1:0]   Grant_Id_Out;
    logic            Busy_Out;
    logic [CW-1:0]   Read_Count_Out;
    logic            SROM_Enable_Out;
    logic            SROM_Read_Enable_Out;
    logic [AW-1:0]   SROM_Address_Out;
    logic [DW-1:0]   SROM_Read_Data_In;

    always #5 Clk_In = ~Clk_In;

    srom_single_port_arbiter #(
        .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)
    ) dut (
        .Clk_In               (Clk_In),
        .Reset_In             (Reset_In),
        .Req_Valid_In         (Req_Valid_In),
        .Req_Address_In       (Req_Address_In),
        .Req_Ready_Out        (Req_Ready_Out),
        .Rsp_Valid_Out        (Rsp_Valid_Out),
        .Rsp_Ready_In         (Rsp_Ready_In),
        .Rsp_Data_Out         (Rsp_Data_Out),
        .Grant_Id_Out         (Grant_Id_Out),
        .Busy_Out             (Busy_Out),
        .Read_Count_Out       (Read_Count_Out),
        .SROM_Enable_Out      (SROM_Enable_Out),
        .SROM_Read_Enable_Out (SROM_Read_Enable_Out),
        .SROM_Address_Out     (SROM_Address_Out),
        .SROM_Read_Data_In    (SROM_Read_Data_In)
    );

    // SROM stand-in: image word[a] = {a,a}, registered read, output gated by enables.
    logic [DW-1:0] rom_q = '0;
    always @(posedge Clk_In)
        if (SROM_Enable_Out && SROM_Read_Enable_Out) rom_q <= {SROM_Address_Out, SROM_Address_Out};
    assign SROM_Read_Data_In = (SROM_Enable_Out && SROM_Read_Enable_Out) ? rom_q : 'z;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Transaction-level model: owner (-1 = none), cycles since accept, pointer, counter.
    int           m_owner, m_phase, m_ptr, m_cnt, m_gid;
    logic [AW-1:0] m_addr;
    int           grant_log[$];

    task automatic model_reset();
        m_owner = -1; m_phase = 0; m_ptr = 0; m_cnt = 0; m_gid = 0;
        grant_log.delete();
    endtask

    function automatic int rr_pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++)
            if (v[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    // Drive one cycle of inputs (called at posedge+1), check at negedge, advance model.
    task automatic run_cycle(input logic [N-1:0] v, input logic [N*AW-1:0] a, input logic [N-1:0] r);
        int g;
        Req_Valid_In = v; Req_Address_In = a; Rsp_Ready_In = r;
        @(negedge Clk_In);
        g = rr_pick(v, m_ptr);
        chk("read_count", Read_Count_Out, m_cnt);
        chk("busy", Busy_Out, (m_owner >= 0));
        if (m_owner < 0) begin
            chk("req_ready", Req_Ready_Out, (g < 0) ? 0 : (1 << g));
            chk("rsp_valid_idle", Rsp_Valid_Out, 0);
            chk("srom_pins_idle", {SROM_Enable_Out, SROM_Read_Enable_Out, SROM_Address_Out}, 0);
            chk("grant_id_idle", Grant_Id_Out, m_gid);
        end else begin
            chk("req_ready_busy", Req_Ready_Out, 0);
            chk("grant_id", Grant_Id_Out, m_owner);
            if (m_phase < 3) begin
                chk("srom_pins_read", {SROM_Enable_Out, SROM_Read_Enable_Out, SROM_Address_Out}, {2'b11, m_addr});
                chk("rsp_valid_read", Rsp_Valid_Out, 0);
            end else begin
                chk("srom_pins_resp", {SROM_Enable_Out, SROM_Read_Enable_Out, SROM_Address_Out}, 0);
                chk("rsp_valid", Rsp_Valid_Out, 1 << m_owner);
                chk("rsp_data", Rsp_Data_Out, {m_addr, m_addr});
            end
        end
        if (m_owner < 0) begin
            if (g >= 0) begin
                m_owner = g; m_gid = g; m_phase = 1;
                m_addr  = a[g*AW +: AW];
                m_ptr   = (g + 1) % N;
                grant_log.push_back(g);
            end
        end else if (m_phase < 3) begin
            m_phase++;
            if (m_phase == 3 && m_cnt < (1 << CW) - 1) m_cnt++;
        end else if (r[m_owner]) begin
            m_owner = -1;
        end
        @(posedge Clk_In); #1;
    endtask

    initial begin
        Reset_In = 1'b1; Req_Valid_In = '0; Req_Address_In = '0; Rsp_Ready_In = '0;
        model_reset();
        @(negedge Clk_In);
        chk("reset_outputs", {Req_Ready_Out, Rsp_Valid_Out, Rsp_Data_Out, Grant_Id_Out, Busy_Out,
                              Read_Count_Out, SROM_Enable_Out, SROM_Read_Enable_Out, SROM_Address_Out}, 0);
        @(posedge Clk_In); #1;
        Reset_In = 1'b0;

        // Single read held for 3 cycles before the client accepts it.
        run_cycle(4'b0010, 16'h0030, 4'b0000);
        for (int i = 0; i < 5; i++) run_cycle(4'b0000, 16'h0000, 4'b0000);
        run_cycle(4'b0000, 16'h0000, 4'b0010);
        run_cycle(4'b0000, 16'h0000, 4'b0000);
        chk("single_read_count", Read_Count_Out, 1);

        // All requesters continuously valid: strict rotation from the pointer.
        grant_log.delete();
        for (int i = 0; i < 20; i++) run_cycle(4'hF, 16'hDCBA, 4'hF);
        chk("rr_grants", grant_log.size(), 5);
        for (int i = 0; i < grant_log.size(); i++) chk("rr_order", grant_log[i], (i + 2) % N);

        // Address moves after acceptance; read must use the accepted address.
        while (m_owner >= 0) run_cycle(4'b0000, 16'h0000, 4'hF);
        run_cycle(4'b0100, 16'h0500, 4'b0000);
        for (int i = 0; i < 3; i++) run_cycle(4'b0000, 16'h0900, 4'b0000);
        chk("addr_change_data", Rsp_Data_Out, 8'h55);
        run_cycle(4'b0000, 16'h0900, 4'b0100);

        // Reset asserted asynchronously in CAPTURE.
        run_cycle(4'b1000, 16'hF000, 4'b0000);
        run_cycle(4'b0000, 16'h0000, 4'b0000);
        Req_Valid_In = '0;
        #2 Reset_In = 1'b1;
        #1;
        chk("reset_async_en", {SROM_Enable_Out, SROM_Read_Enable_Out}, 0);
        chk("reset_async_rsp", Rsp_Valid_Out, 0);
        chk("reset_async_cnt", Read_Count_Out, 0);
        @(posedge Clk_In); #1;
        Reset_In = 1'b0;
        model_reset();
        for (int i = 0; i < 5; i++) run_cycle(4'b1000, 16'hF000, 4'b1000);
        chk("post_reset_grant", grant_log[0], 3);
        for (int i = 0; i < 6; i++) run_cycle(4'hF, 16'h4321, 4'hF);

        // Random traffic; also pushes the 4-bit counter into saturation.
        for (int i = 0; i < 600; i++)
            run_cycle(N'($urandom_range(0, 15)), (N*AW)'($urandom), N'($urandom_range(0, 15)));
        chk("count_saturated", Read_Count_Out, 4'hF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
